semaforo_ctrl: RTL

Sequential two-approach traffic-light controller that arbitrates right-of-way between road A and road B using vehicle-presence sensors. It replaces the combinational `semafaro` decision logic in the intersection design. It adds timed green, yellow and all-red phases, minimum and maximum green enforcement, and rest-on-green when no conflicting demand exists. Outputs drive the lamp drivers directly and provide per-road go flags.

---
 rtl/semaforo_ctrl_pkg.sv | 35 +++
 rtl/semaforo_ctrl_timer.sv | 23 ++
 rtl/semaforo_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/semaforo_ctrl_pkg.sv
// Shared definitions for the two-road traffic-light controller:
// phase codes, lamp encodings and the phase-to-lamp decode.
`timescale 1ns/1ps
package semaforo_ctrl_pkg;

    typedef enum logic [2:0] {
        VERM_BA = 3'd0,
        A_VERDE = 3'd1,
        A_AMAR  = 3'd2,
        VERM_AB = 3'd3,
        B_VERDE = 3'd4,
        B_AMAR  = 3'd5
    } state_t;

    localparam logic [2:0] LUZ_VERM  = 3'b100;
    localparam logic [2:0] LUZ_AMAR  = 3'b010;
    localparam logic [2:0] LUZ_VERDE = 3'b001;

    function automatic logic [2:0] luz_a_of(state_t s);
        case (s)
            A_VERDE: luz_a_of = LUZ_VERDE;
            A_AMAR:  luz_a_of = LUZ_AMAR;
            default: luz_a_of = LUZ_VERM;
        endcase
    endfunction

    function automatic logic [2:0] luz_b_of(state_t s);
        case (s)
            B_VERDE: luz_b_of = LUZ_VERDE;
            B_AMAR:  luz_b_of = LUZ_AMAR;
            default: luz_b_of = LUZ_VERM;
        endcase
    endfunction

endpackage

// File: rtl/semaforo_ctrl_timer.sv
// Phase counter: clears on request, otherwise counts up and holds at limit.
`timescale 1ns/1ps
module semaforo_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt < limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/semaforo_ctrl.sv
// Two-approach traffic-light controller with timed green/yellow/all-red
// phases, min/max green and rest-on-green. Lamps come from registers only.
`timescale 1ns/1ps
module semaforo_ctrl
    import semaforo_ctrl_pkg::*;
#(
    parameter int T_VERDE_MIN = 4,
    parameter int T_VERDE_MAX = 8,
    parameter int T_AMARELO   = 2,
    parameter int T_VERMELHO  = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    output logic [2:0] luz_a,
    output logic [2:0] luz_b,
    output logic       As,
    output logic       Bs,
    output logic [2:0] fase
);

    localparam logic [CNT_W-1:0] VERDE_LAST = CNT_W'(T_VERDE_MAX - 1);
    localparam logic [CNT_W-1:0] AMAR_LAST  = CNT_W'(T_AMARELO - 1);
    localparam logic [CNT_W-1:0] VERM_LAST  = CNT_W'(T_VERMELHO - 1);
    localparam logic [CNT_W:0]   VERDE_MIN  = (CNT_W+1)'(T_VERDE_MIN);

    state_t           state;
    state_t           next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic [CNT_W:0]   cnt_p1;
    logic             min_ok;
    logic             max_hit;
    logic             clr;

    assign cnt_p1  = {1'b0, cnt} + 1'b1;
    assign min_ok  = (cnt_p1 >= VERDE_MIN);
    assign max_hit = (cnt == VERDE_LAST);
    assign limit   = (state == A_VERDE || state == B_VERDE) ? VERDE_LAST : '1;
    assign clr     = (next != state);

    // Green only yields to opposing demand; max green cuts in only when both roads want to go.
    always_comb begin
        next = state;
        case (state)
            VERM_BA: if (cnt == VERM_LAST) next = A_VERDE;
            A_VERDE: if (min_ok && B && (!A || max_hit)) next = A_AMAR;
            A_AMAR:  if (cnt == AMAR_LAST) next = VERM_AB;
            VERM_AB: if (cnt == VERM_LAST) next = B_VERDE;
            B_VERDE: if (min_ok && A && (!B || max_hit)) next = B_AMAR;
            B_AMAR:  if (cnt == AMAR_LAST) next = VERM_BA;
            default: next = VERM_BA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= VERM_BA;
            luz_a <= LUZ_VERM;
            luz_b <= LUZ_VERM;
        end else begin
            state <= next;
            luz_a <= luz_a_of(next);
            luz_b <= luz_b_of(next);
        end
    end

    assign fase = state;
    assign As   = luz_a[0];
    assign Bs   = luz_b[0];

    semaforo_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .limit (limit),
        .cnt   (cnt)
    );

endmodule
